vga_timing_gen: RTL and testbench

//  Source end of the pixel-coordinate interface consumed by every sprite/background renderer.

---
 rtl/vga_timing_gen_if.sv | 20 ++
 rtl/vga_timing_gen.sv | 93 +++++++++
 tb/tb_vga_timing_gen.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Pixel-coordinate bundle driven by the VGA timing generator and consumed by renderers.
interface vga_timing_gen_if #(
  parameter int FC_W = 8
);
  logic [9:0]      DrawX;
  logic [9:0]      DrawY;
  logic            hs;
  logic            vs;
  logic            blank;
  logic            frame_start;
  logic [FC_W-1:0] frame_count;

  modport master (
    output DrawX, DrawY, hs, vs, blank, frame_start, frame_count
  );

  modport slave (
    input DrawX, DrawY, hs, vs, blank, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing: free-running pixel/line counters with sync, blank and frame pulses
// all registered from the next-state counters so they line up with DrawX/DrawY.
module vga_timing_gen #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int FC_W   = 8
) (
  input  logic            vga_clk,
  input  logic            reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_totals
      $error("vga_timing_gen: H_TOT and V_TOT must both fit a 10-bit counter");
    end
  endgenerate

  // 11-bit constants so sync end points equal to 1024 still compare correctly.
  localparam logic [10:0] H_LAST   = 11'(H_TOT - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOT - 1);
  localparam logic [10:0] H_VIS_W  = 11'(H_VIS);
  localparam logic [10:0] V_VIS_W  = 11'(V_VIS);
  localparam logic [10:0] HS_BEG   = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG   = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VIS + V_FP + V_SYNC);

  logic [9:0]      hc, vc;
  logic [9:0]      hc_n, vc_n;
  logic [10:0]     hx_n, vy_n;
  logic            h_wrap, v_last;
  logic            hs_q, vs_q, blank_q, fs_q;
  logic            hs_n, vs_n, blank_n, fs_n;
  logic [FC_W-1:0] fc_q;

  always_comb begin
    h_wrap = ({1'b0, hc} == H_LAST);
    v_last = ({1'b0, vc} == V_LAST);
    hc_n   = h_wrap ? 10'd0 : hc + 10'd1;
    vc_n   = vc;
    if (h_wrap) begin
      vc_n = v_last ? 10'd0 : vc + 10'd1;
    end
    hx_n    = {1'b0, hc_n};
    vy_n    = {1'b0, vc_n};
    blank_n = (hx_n < H_VIS_W) && (vy_n < V_VIS_W);
    hs_n    = !((hx_n >= HS_BEG) && (hx_n < HS_END));
    vs_n    = !((vy_n >= VS_BEG) && (vy_n < VS_END));
    // Only a genuine wrap from the last pixel marks a frame; reset release lands on (1,0).
    fs_n    = h_wrap && v_last;
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc      <= '0;
      vc      <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      fs_q    <= 1'b0;
      fc_q    <= '0;
    end else begin
      hc      <= hc_n;
      vc      <= vc_n;
      hs_q    <= hs_n;
      vs_q    <= vs_n;
      blank_q <= blank_n;
      fs_q    <= fs_n;
      if (fs_n) begin
        fc_q <= fc_q + FC_W'(1);
      end
    end
  end

  assign vga.DrawX       = hc;
  assign vga.DrawY       = vc;
  assign vga.hs          = hs_q;
  assign vga.vs          = vs_q;
  assign vga.blank       = blank_q;
  assign vga.frame_start = fs_q;
  assign vga.frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for line/reset behaviour, a shrunken
// instance (FC_W=2) so whole frames fit in a short run.
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  logic rst_a   = 1'b1;
  logic rst_b   = 1'b1;
  longint ka = 0;
  longint kb = 0;
  int total = 0;
  int bad   = 0;

  always #20 vga_clk = ~vga_clk;

  vga_timing_gen_if #(.FC_W(8)) if_a ();
  vga_timing_gen_if #(.FC_W(2)) if_b ();

  vga_timing_gen #(.FC_W(8)) dut_a (
    .vga_clk (vga_clk),
    .reset   (rst_a),
    .vga     (if_a)
  );

  vga_timing_gen #(
    .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VIS(6),  .V_FP(2), .V_SYNC(2), .V_BP(3),
    .FC_W(2)
  ) dut_b (
    .vga_clk (vga_clk),
    .reset   (rst_b),
    .vga     (if_b)
  );

  // Edges seen since reset release; 0 while reset is held.
  always @(posedge vga_clk) begin
    ka <= rst_a ? 0 : ka + 1;
    kb <= rst_b ? 0 : kb + 1;
  end

  // Reference: position after k edges from release is k mod frame length, with pixel 0 skipped
  // only because the count starts at 1. Packed as {x,y,hs,vs,blank,fs,fc[7:0]}.
  function automatic logic [31:0] model(input longint k, input int hv, hf, hsw, hb,
                                        input int vv, vf, vsw, vb, fcw);
    longint ht, vt, ft, p, x, y, fc;
    logic hs_e, vs_e, bl, fs;
    if (k <= 0) return {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    ft = ht * vt;
    p  = k % ft;
    x  = p % ht;
    y  = p / ht;
    fc = (k / ft) % (longint'(1) << fcw);
    hs_e = !(x >= hv + hf && x < hv + hf + hsw);
    vs_e = !(y >= vv + vf && y < vv + vf + vsw);
    bl   = (x < hv) && (y < vv);
    fs   = (p == 0);
    return {10'(x), 10'(y), hs_e, vs_e, bl, fs, 8'(fc)};
  endfunction

  function automatic logic [31:0] exp_a();
    return rst_a ? model(0, 640, 16, 96, 48, 480, 10, 2, 33, 8)
                 : model(ka, 640, 16, 96, 48, 480, 10, 2, 33, 8);
  endfunction

  function automatic logic [31:0] exp_b();
    return rst_b ? model(0, 16, 2, 4, 3, 6, 2, 2, 3, 2)
                 : model(kb, 16, 2, 4, 3, 6, 2, 2, 3, 2);
  endfunction

  function automatic logic [31:0] obs_a();
    return {if_a.DrawX, if_a.DrawY, if_a.hs, if_a.vs, if_a.blank, if_a.frame_start,
            if_a.frame_count};
  endfunction

  function automatic logic [31:0] obs_b();
    return {if_b.DrawX, if_b.DrawY, if_b.hs, if_b.vs, if_b.blank, if_b.frame_start,
            6'd0, if_b.frame_count};
  endfunction

  task automatic cyc();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    for (int i = 0; i < 3; i++) begin
      cyc();
      #($urandom_range(0, 15));
      got = obs_a(); exp = exp_a(); total++;
      if (got !== exp) begin bad++; $display("FAIL reset_a got=%h exp=%h", got, exp); end
      got = obs_b(); exp = exp_b(); total++;
      if (got !== exp) begin bad++; $display("FAIL reset_b got=%h exp=%h", got, exp); end
    end
  endtask

  task automatic test_line();
    logic [31:0] got, exp;
    int hs_low = 0;
    int vis = 0;
    int n = 1600 + $urandom_range(0, 400);
    @(negedge vga_clk);
    rst_a = 1'b0;
    for (int i = 0; i < n; i++) begin
      cyc();
      got = obs_a(); exp = exp_a(); total++;
      if (got !== exp) begin bad++; $display("FAIL line k=%0d got=%h exp=%h", ka, got, exp); end
      if (ka >= 800 && ka < 1600) begin
        if (!if_a.hs) hs_low++;
        if (if_a.blank) vis++;
      end
    end
    total++;
    if (hs_low !== 96) begin bad++; $display("FAIL hs_width got=%0d exp=96", hs_low); end
    total++;
    if (vis !== 640) begin bad++; $display("FAIL visible_px got=%0d exp=640", vis); end
  endtask

  task automatic test_async_reset();
    logic [31:0] got, exp;
    longint target;
    target = longint'($urandom_range(3, 20)) * 800 + longint'($urandom_range(1, 798));
    while (ka < target) begin
      cyc();
      got = obs_a(); exp = exp_a(); total++;
      if (got !== exp) begin bad++; $display("FAIL run k=%0d got=%h exp=%h", ka, got, exp); end
    end
    #($urandom_range(2, 15));
    rst_a = 1'b1;
    #1;
    got = obs_a(); exp = exp_a(); total++;
    if (got !== exp) begin bad++; $display("FAIL async_rst got=%h exp=%h", got, exp); end
    repeat (2) cyc();
    @(negedge vga_clk);
    rst_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      got = obs_a(); exp = exp_a(); total++;
      if (got !== exp) begin bad++; $display("FAIL restart k=%0d got=%h exp=%h", ka, got, exp); end
    end
  endtask

  task automatic test_frames();
    logic [31:0] got, exp;
    logic [1:0] fcq[$];
    logic [1:0] want[5];
    int vs_low = 0;
    int vblank_vis = 0;
    int n = 5 * 325 + $urandom_range(1, 100);
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd0; want[4] = 2'd1;
    @(negedge vga_clk);
    rst_b = 1'b0;
    for (int i = 0; i < n; i++) begin
      cyc();
      got = obs_b(); exp = exp_b(); total++;
      if (got !== exp) begin bad++; $display("FAIL frame k=%0d got=%h exp=%h", kb, got, exp); end
      if (if_b.frame_start) fcq.push_back(if_b.frame_count);
      if (kb >= 325 && kb < 650) begin
        if (!if_b.vs) vs_low++;
        if (if_b.DrawY >= 10'd6 && if_b.blank) vblank_vis++;
      end
    end
    total++;
    if (vs_low !== 50) begin bad++; $display("FAIL vs_width got=%0d exp=50", vs_low); end
    total++;
    if (vblank_vis !== 0) begin bad++; $display("FAIL vblank_vis got=%0d exp=0", vblank_vis); end
    total++;
    if (fcq.size() !== 5) begin
      bad++; $display("FAIL fs_count got=%0d exp=5", fcq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (fcq[i] !== want[i]) begin
          bad++; $display("FAIL fc_seq[%0d] got=%0d exp=%0d", i, fcq[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got, exp;
    int run;
    for (int it = 0; it < 6; it++) begin
      run = $urandom_range(1, 800);
      for (int i = 0; i < run; i++) begin
        cyc();
        got = obs_b(); exp = exp_b(); total++;
        if (got !== exp) begin bad++; $display("FAIL b2b k=%0d got=%h exp=%h", kb, got, exp); end
      end
      #($urandom_range(2, 15));
      rst_b = 1'b1;
      #1;
      got = obs_b(); exp = exp_b(); total++;
      if (got !== exp) begin bad++; $display("FAIL b2b_rst got=%h exp=%h", got, exp); end
      repeat ($urandom_range(1, 3)) cyc();
      got = obs_b(); exp = exp_b(); total++;
      if (got !== exp) begin bad++; $display("FAIL b2b_hold got=%h exp=%h", got, exp); end
      @(negedge vga_clk);
      rst_b = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_async_reset();
    test_frames();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
